// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer between the 24-bit ALU and writeback; commits {C,V,Z} on retire.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow flag set by retiring flag-setting ops.
module alu_result_buffer #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEST_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InResult,
  input  logic              InZero,
  input  logic              InOverflow,
  input  logic              InCarry,
  input  logic [DEST_W-1:0] InDest,
  input  logic              InSetFlags,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutResult,
  output logic [DEST_W-1:0] OutDest,
  output logic [2:0]        OutFlags,
  output logic [2:0]        StatusFlags,
  output logic [1:0]        Occupancy,
  output logic              StickyOvf,
  input  logic              ClearSticky
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              valid;
  logic              push;
  logic              pop;
  logic              commit;
  logic              head_from_in;
  logic              head_from_skid;
  logic              skid_load;

  logic [DATA_W-1:0] head_result;
  logic [DEST_W-1:0] head_dest;
  logic [2:0]        head_flags;
  logic              head_set;
  logic [DATA_W-1:0] skid_result;
  logic [DEST_W-1:0] skid_dest;
  logic [2:0]        skid_flags;
  logic              skid_set;

  logic [2:0]        in_flags;

  // Ready depends only on state so it never combinationally tracks OutReady.
  assign InReady  = ~Reset & (state != FULL);
  assign push     = InValid & InReady;
  assign pop      = valid & OutReady;
  assign commit   = pop & head_set & ~Flush;
  assign in_flags = {InCarry, InOverflow, InZero};

  assign OutValid  = valid;
  assign OutResult = head_result;
  assign OutDest   = head_dest;
  assign OutFlags  = head_flags;
  assign Occupancy = state;

  always_comb begin
    state_next     = state;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (Flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_next   = ONE;
            head_from_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_from_in = 1'b1;
          end else if (push) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next     = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= EMPTY;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      valid <= (state_next != EMPTY);
    end
  end

  // Head holds its last value while empty so outputs stay deterministic.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_result <= '0;
      head_dest   <= '0;
      head_flags  <= 3'b000;
      head_set    <= 1'b0;
      skid_result <= '0;
      skid_dest   <= '0;
      skid_flags  <= 3'b000;
      skid_set    <= 1'b0;
    end else begin
      if (head_from_in) begin
        head_result <= InResult;
        head_dest   <= InDest;
        head_flags  <= in_flags;
        head_set    <= InSetFlags;
      end else if (head_from_skid) begin
        head_result <= skid_result;
        head_dest   <= skid_dest;
        head_flags  <= skid_flags;
        head_set    <= skid_set;
      end
      if (skid_load) begin
        skid_result <= InResult;
        skid_dest   <= InDest;
        skid_flags  <= in_flags;
        skid_set    <= InSetFlags;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      StatusFlags <= 3'b000;
    end else if (commit) begin
      StatusFlags <= head_flags;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky;

  // A retiring overflow beats a same-cycle clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sticky <= 1'b0;
    end else if (commit && head_flags[1]) begin
      sticky <= 1'b1;
    end else if (ClearSticky) begin
      sticky <= 1'b0;
    end
  end

  assign StickyOvf = sticky;
`else
  logic unused_clear_sticky;

  assign unused_clear_sticky = ClearSticky;
  assign StickyOvf           = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed vector table plus random traffic
// against a queue-based reference model.
module tb_alu_result_buffer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [23:0] InResult;
  logic        InZero;
  logic        InOverflow;
  logic        InCarry;
  logic [3:0]  InDest;
  logic        InSetFlags;
  logic        OutValid;
  logic        OutReady;
  logic [23:0] OutResult;
  logic [3:0]  OutDest;
  logic [2:0]  OutFlags;
  logic [2:0]  StatusFlags;
  logic [1:0]  Occupancy;
  logic        StickyOvf;
  logic        ClearSticky;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

`ifdef ALU_STICKY_OVF_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  alu_result_buffer #(.DATA_W(24), .DEST_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .InResult(InResult),
    .InZero(InZero), .InOverflow(InOverflow), .InCarry(InCarry),
    .InDest(InDest), .InSetFlags(InSetFlags),
    .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
    .OutDest(OutDest), .OutFlags(OutFlags), .StatusFlags(StatusFlags),
    .Occupancy(Occupancy), .StickyOvf(StickyOvf), .ClearSticky(ClearSticky)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        fl, iv;
    logic [23:0] res;
    logic [2:0]  cvz;
    logic [3:0]  dst;
    logic        set, ordy, clr;
    logic        rdy;
    logic [1:0]  occ;
    logic        ov;
    logic [23:0] ores;
    logic [2:0]  stat;
    logic        stk;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [23:0] res,
                              input logic [2:0] cvz, input logic set, input logic ordy,
                              input logic clr, input logic rdy, input logic [1:0] occ,
                              input logic ov, input logic [23:0] ores, input logic [2:0] stat,
                              input logic stk);
    vec_t v;
    v.fl = fl; v.iv = iv; v.res = res; v.cvz = cvz; v.dst = 4'd3; v.set = set;
    v.ordy = ordy; v.clr = clr; v.rdy = rdy; v.occ = occ; v.ov = ov; v.ores = ores;
    v.stat = stat; v.stk = stk;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [23:0] res,
                       input logic [2:0] cvz, input logic [3:0] dst, input logic set,
                       input logic ordy, input logic clr);
    Reset = rst; Flush = fl; InValid = iv; InResult = res;
    {InCarry, InOverflow, InZero} = cvz; InDest = dst; InSetFlags = set;
    OutReady = ordy; ClearSticky = clr;
  endtask

  // Reference model: a plain queue of pending ops plus committed state.
  typedef struct {
    logic [23:0] res;
    logic [3:0]  dst;
    logic [2:0]  cvz;
    logic        set;
  } ent_t;

  ent_t        mq[$];
  ent_t        last_head;
  logic [2:0]  m_status;
  logic        m_sticky;

  task automatic model_reset();
    mq.delete();
    last_head = '{res: 24'h0, dst: 4'h0, cvz: 3'b000, set: 1'b0};
    m_status  = 3'b000;
    m_sticky  = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic fl, input logic iv, input ent_t e,
                            input logic ordy, input logic clr);
    bit can_push, can_pop, retire_v;
    ent_t h;
    if (rst) begin
      model_reset();
      return;
    end
    if (clr) m_sticky = 1'b0;
    if (fl) begin
      mq.delete();
      return;
    end
    can_push = iv && (mq.size() < 2);
    can_pop  = ordy && (mq.size() > 0);
    retire_v = 1'b0;
    if (can_pop) begin
      h = mq.pop_front();
      if (h.set) begin
        m_status = h.cvz;
        retire_v = h.cvz[1];
      end
    end
    if (retire_v && STICKY_EN) m_sticky = 1'b1;
    if (can_push) mq.push_back(e);
    if (mq.size() > 0) last_head = mq[0];
  endtask

  vec_t tbl[14];

  initial begin
    ent_t e;
    logic rst, fl, iv, ordy, clr;
    int   ready_wait;

    // rdy is the pre-edge InReady; the rest are observed just after the edge.
    tbl[0]  = mk(0, 1, 24'h000005, 3'b000, 1, 1, 0, 1, 2'd1, 1, 24'h000005, 3'b000, 0);
    tbl[1]  = mk(0, 0, 24'h000000, 3'b000, 0, 1, 0, 1, 2'd0, 0, 24'h000005, 3'b000, 0);
    tbl[2]  = mk(0, 1, 24'hAAAAAA, 3'b100, 1, 0, 0, 1, 2'd1, 1, 24'hAAAAAA, 3'b000, 0);
    tbl[3]  = mk(0, 1, 24'h555555, 3'b001, 0, 0, 0, 1, 2'd2, 1, 24'hAAAAAA, 3'b000, 0);
    tbl[4]  = mk(0, 1, 24'h123456, 3'b111, 1, 1, 0, 0, 2'd1, 1, 24'h555555, 3'b100, 0);
    tbl[5]  = mk(0, 0, 24'h000000, 3'b000, 0, 1, 0, 1, 2'd0, 0, 24'h555555, 3'b100, 0);
    tbl[6]  = mk(0, 1, 24'h000111, 3'b000, 0, 0, 0, 1, 2'd1, 1, 24'h000111, 3'b100, 0);
    tbl[7]  = mk(0, 1, 24'h7FFFFF, 3'b010, 1, 1, 0, 1, 2'd1, 1, 24'h7FFFFF, 3'b100, 0);
    tbl[8]  = mk(0, 0, 24'h000000, 3'b000, 0, 1, 0, 1, 2'd0, 0, 24'h7FFFFF, 3'b010, 1);
    tbl[9]  = mk(0, 0, 24'h000000, 3'b000, 0, 0, 0, 1, 2'd0, 0, 24'h7FFFFF, 3'b010, 1);
    tbl[10] = mk(0, 1, 24'h000AAA, 3'b111, 1, 0, 0, 1, 2'd1, 1, 24'h000AAA, 3'b010, 1);
    tbl[11] = mk(0, 1, 24'h000BBB, 3'b111, 1, 0, 0, 1, 2'd2, 1, 24'h000AAA, 3'b010, 1);
    tbl[12] = mk(1, 1, 24'h000CCC, 3'b001, 1, 1, 0, 0, 2'd0, 0, 24'h000AAA, 3'b010, 1);
    tbl[13] = mk(0, 0, 24'h000000, 3'b000, 0, 0, 1, 1, 2'd0, 0, 24'h000AAA, 3'b010, 0);

    // Two reset cycles; ready must be low throughout.
    drive(1, 0, 1, 24'h0, 3'b000, 4'h0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      #1 chk("ready_in_reset", 32'(InReady), 32'd0);
    end
    @(negedge Clock);
    drive(0, 0, 0, 24'h0, 3'b000, 4'h0, 0, 0, 0);
    #1;
    chk("idle_ready", 32'(InReady), 32'd1);
    chk("idle_valid", 32'(OutValid), 32'd0);
    chk("idle_occ", 32'(Occupancy), 32'd0);
    chk("idle_status", 32'(StatusFlags), 32'd0);
    chk("idle_result", 32'(OutResult), 32'd0);
    chk("idle_dest", 32'(OutDest), 32'd0);
    chk("idle_flags", 32'(OutFlags), 32'd0);
    chk("idle_sticky", 32'(StickyOvf), 32'd0);

    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      drive(0, tbl[i].fl, tbl[i].iv, tbl[i].res, tbl[i].cvz, tbl[i].dst, tbl[i].set,
            tbl[i].ordy, tbl[i].clr);
      #1 chk($sformatf("v%0d_ready", i), 32'(InReady), 32'(tbl[i].rdy));
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_occ", i), 32'(Occupancy), 32'(tbl[i].occ));
      chk($sformatf("v%0d_valid", i), 32'(OutValid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_result", i), 32'(OutResult), 32'(tbl[i].ores));
      chk($sformatf("v%0d_status", i), 32'(StatusFlags), 32'(tbl[i].stat));
      chk($sformatf("v%0d_sticky", i), 32'(StickyOvf), 32'(tbl[i].stk & STICKY_EN));
    end

    // Sticky set wins over a same-cycle clear.
    @(negedge Clock);
    drive(0, 0, 1, 24'h00ABCD, 3'b010, 4'h9, 1, 0, 0);
    @(negedge Clock);
    drive(0, 0, 0, 24'h0, 3'b000, 4'h0, 0, 1, 1);
    @(posedge Clock);
    #1;
    chk("set_beats_clear_sticky", 32'(StickyOvf), 32'(STICKY_EN));
    chk("set_beats_clear_status", 32'(StatusFlags), 32'd2);

    // Bounded wait for ready after a full buffer drains.
    @(negedge Clock);
    drive(0, 0, 1, 24'h1, 3'b000, 4'h1, 0, 0, 0);
    @(negedge Clock);
    drive(0, 0, 1, 24'h2, 3'b000, 4'h2, 0, 0, 0);
    @(negedge Clock);
    drive(0, 0, 0, 24'h0, 3'b000, 4'h0, 0, 1, 0);
    ready_wait = 0;
    while (InReady !== 1'b1 && ready_wait < 10) begin
      @(negedge Clock);
      ready_wait++;
    end
    chk("drain_ready_timeout", 32'(ready_wait < 10), 32'd1);

    // Randomized traffic against the reference model, including occasional reset/flush.
    @(negedge Clock);
    drive(1, 0, 0, 24'h0, 3'b000, 4'h0, 0, 0, 0);
    @(posedge Clock);
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge Clock);
      rst  = ($urandom_range(0, 59) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < 6);
      clr  = ($urandom_range(0, 19) == 0);
      e.res = 24'($urandom);
      e.dst = 4'($urandom);
      e.cvz = 3'($urandom);
      e.set = 1'($urandom);
      drive(rst, fl, iv, e.res, e.cvz, e.dst, e.set, ordy, clr);
      #1 chk("rnd_ready", 32'(InReady), 32'(!rst && mq.size() < 2));
      @(posedge Clock);
      model_step(rst, fl, iv, e, ordy, clr);
      #1;
      chk("rnd_occ", 32'(Occupancy), 32'(mq.size()));
      chk("rnd_valid", 32'(OutValid), 32'(mq.size() > 0));
      chk("rnd_result", 32'(OutResult), 32'(last_head.res));
      chk("rnd_dest", 32'(OutDest), 32'(last_head.dst));
      chk("rnd_flags", 32'(OutFlags), 32'(last_head.cvz));
      chk("rnd_status", 32'(StatusFlags), 32'(m_status));
      chk("rnd_sticky", 32'(StickyOvf), 32'(m_sticky));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
